// File: rtl/pixel_pkg.sv
// Shared pixel-pipeline constants, FSM state type and coordinate saturation.
// Coordinates are signed COORD_W words; ramps accumulate in ACC_W.
package pixel_pkg;

   localparam int COORD_W   = 16;
   localparam int ACC_W     = 28;
   localparam int H_RES_DEF = 640;
   localparam int V_RES_DEF = 480;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } vp_state_e;

   // In range when every bit above the COORD_W sign bit matches it.
   function automatic logic signed [COORD_W-1:0] sat_coord(input logic signed [ACC_W-1:0] a);
      logic [ACC_W-COORD_W:0] top;
      top = a[ACC_W-1:COORD_W-1];
      if ((&top) || !(|top)) begin
         sat_coord = a[COORD_W-1:0];
      end else if (a[ACC_W-1]) begin
         sat_coord = {1'b1, {(COORD_W-1){1'b0}}};
      end else begin
         sat_coord = {1'b0, {(COORD_W-1){1'b1}}};
      end
   endfunction

endpackage

// File: rtl/coord_axis_acc.sv
// One axis of the viewport ramp: shadowed origin/step, linear accumulator and
// a registered saturated coordinate that tracks the accumulator's next state.
module coord_axis_acc
   import pixel_pkg::*;
(
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      load_i,
   input  logic signed [COORD_W-1:0] origin_i,
   input  logic        [COORD_W-1:0] step_i,
   input  logic                      inc_i,
   input  logic                      dir_i,
   input  logic                      wrap_i,
   output logic signed [COORD_W-1:0] coord_o
);

   logic signed [COORD_W-1:0] origin_q;
   logic        [COORD_W-1:0] step_q;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [COORD_W-1:0] coord_q;
   logic signed [ACC_W-1:0]   step_ext;

   assign step_ext = {{(ACC_W-COORD_W){1'b0}}, step_q};

   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = {{(ACC_W-COORD_W){origin_i[COORD_W-1]}}, origin_i};
      end else if (wrap_i) begin
         acc_d = {{(ACC_W-COORD_W){origin_q[COORD_W-1]}}, origin_q};
      end else if (inc_i) begin
         acc_d = dir_i ? (acc_q - step_ext) : (acc_q + step_ext);
      end
   end

   // Saturation only shapes the output word; the accumulator stays linear.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         origin_q <= '0;
         step_q   <= '0;
         acc_q    <= '0;
         coord_q  <= '0;
      end else begin
         if (load_i) begin
            origin_q <= origin_i;
            step_q   <= step_i;
         end
         acc_q   <= acc_d;
         coord_q <= sat_coord(acc_d);
      end
   end

   assign coord_o = coord_q;

endmodule

// File: rtl/viewport_coord_gen.sv
// Raster-order complex-plane sample source; one LOAD bubble per frame, then 1 point/clk.
// Outputs hold exactly while valid && !ready; viewport cfg is sampled only in LOAD.
module viewport_coord_gen
   import pixel_pkg::*;
#(
   parameter int H_RES = H_RES_DEF,
   parameter int V_RES = V_RES_DEF
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      ready,
   input  logic signed [COORD_W-1:0] cfg_origin_re,
   input  logic signed [COORD_W-1:0] cfg_origin_im,
   input  logic        [COORD_W-1:0] cfg_step,
   output logic                      valid,
   output logic signed [COORD_W-1:0] x,
   output logic signed [COORD_W-1:0] y,
   output logic                      first,
   output logic                      lastx,
   output logic                      lasty
);

   localparam int PXW = $clog2(H_RES);
   localparam int PYW = $clog2(V_RES);
   localparam logic [PXW-1:0] PX_LAST = PXW'(H_RES - 1);
   localparam logic [PYW-1:0] PY_LAST = PYW'(V_RES - 1);

   vp_state_e      state_q, state_d;
   logic [PXW-1:0] px_q, px_d;
   logic [PYW-1:0] py_q, py_d;
   logic           valid_q, valid_d;
   logic           first_q, first_d;
   logic           lastx_q, lastx_d;
   logic           lasty_q, lasty_d;
   logic           load, inc_re, wrap_re, inc_im, wrap_im;

   always_comb begin
      state_d = state_q;
      px_d    = px_q;
      py_d    = py_q;
      load    = 1'b0;
      inc_re  = 1'b0;
      wrap_re = 1'b0;
      inc_im  = 1'b0;
      wrap_im = 1'b0;
      case (state_q)
         LOAD: begin
            load    = 1'b1;
            px_d    = '0;
            py_d    = '0;
            state_d = RUN;
         end
         RUN: begin
            if (ready) begin
               if (px_q == PX_LAST) begin
                  px_d    = '0;
                  wrap_re = 1'b1;
                  if (py_q == PY_LAST) begin
                     py_d    = '0;
                     wrap_im = 1'b1;
                     state_d = LOAD;
                  end else begin
                     py_d   = py_q + 1'b1;
                     inc_im = 1'b1;
                  end
               end else begin
                  px_d   = px_q + 1'b1;
                  inc_re = 1'b1;
               end
            end
         end
      endcase
      // Framing is registered alongside the coordinates, so derive it from next state.
      valid_d = (state_d == RUN);
      first_d = valid_d && (px_d == '0) && (py_d == '0);
      lastx_d = valid_d && (px_d == PX_LAST);
      lasty_d = lastx_d && (py_d == PY_LAST);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= LOAD;
         px_q    <= '0;
         py_q    <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         lastx_q <= 1'b0;
         lasty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         px_q    <= px_d;
         py_q    <= py_d;
         valid_q <= valid_d;
         first_q <= first_d;
         lastx_q <= lastx_d;
         lasty_q <= lasty_d;
      end
   end

   // Imag axis points up: rows descend by one step.
   coord_axis_acc u_re (
      .clk      (clk),
      .resetn   (resetn),
      .load_i   (load),
      .origin_i (cfg_origin_re),
      .step_i   (cfg_step),
      .inc_i    (inc_re),
      .dir_i    (1'b0),
      .wrap_i   (wrap_re),
      .coord_o  (x)
   );

   coord_axis_acc u_im (
      .clk      (clk),
      .resetn   (resetn),
      .load_i   (load),
      .origin_i (cfg_origin_im),
      .step_i   (cfg_step),
      .inc_i    (inc_im),
      .dir_i    (1'b1),
      .wrap_i   (wrap_im),
      .coord_o  (y)
   );

   assign valid = valid_q;
   assign first = first_q;
   assign lastx = lastx_q;
   assign lasty = lasty_q;

endmodule

// File: tb/tb_viewport_coord_gen.sv
// Scoreboard bench: frames of expected points are queued from a plain-arithmetic
// model; a monitor pops and compares on every accepted point.
module tb_viewport_coord_gen;

   localparam int H = 4;
   localparam int V = 3;

   logic               clk = 1'b0;
   logic               resetn = 1'b0;
   logic               ready = 1'b0;
   logic signed [15:0] cfg_origin_re = '0;
   logic signed [15:0] cfg_origin_im = '0;
   logic        [15:0] cfg_step = '0;
   logic               valid;
   logic signed [15:0] x, y;
   logic               first, lastx, lasty;

   viewport_coord_gen #(.H_RES(H), .V_RES(V)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .ready         (ready),
      .cfg_origin_re (cfg_origin_re),
      .cfg_origin_im (cfg_origin_im),
      .cfg_step      (cfg_step),
      .valid         (valid),
      .x             (x),
      .y             (y),
      .first         (first),
      .lastx         (lastx),
      .lasty         (lasty)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      bit f;
      bit lx;
      bit ly;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   acc_total = 0;

   function automatic void check(input bit ok, input string name, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endfunction

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic push_frame(input int ore, input int oim, input int st);
      exp_t e;
      for (int r = 0; r < V; r++) begin
         for (int c = 0; c < H; c++) begin
            e.x  = sat16(ore + c * st);
            e.y  = sat16(oim - r * st);
            e.f  = (r == 0) && (c == 0);
            e.lx = (c == H - 1);
            e.ly = (c == H - 1) && (r == V - 1);
            q.push_back(e);
         end
      end
   endtask

   function automatic bit pick_ready(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      return $urandom_range(0, 99) < 65;
   endfunction

   task automatic do_reset();
      ready  = 1'b0;
      resetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic run_phase(input int ore, input int oim, input int st, input int nfr,
                            input int mode, input int chg_at, input int chg_re, input int rst_at);
      int base;
      int cyc;
      bit done_chg;
      bit done_rst;
      cfg_origin_re = 16'(ore);
      cfg_origin_im = 16'(oim);
      cfg_step      = 16'(st);
      q.delete();
      do_reset();
      for (int f = 0; f < nfr; f++) push_frame(ore, oim, st);
      base = acc_total;
      cyc = 0;
      done_chg = 1'b0;
      done_rst = 1'b0;
      while (q.size() > 0 && cyc < 4000) begin
         @(posedge clk);
         #1;
         ready = (q.size() > 0) && pick_ready(mode, cyc);
         cyc++;
         if (chg_at >= 0 && !done_chg && (acc_total - base) >= chg_at) begin
            done_chg = 1'b1;
            cfg_origin_re = 16'(chg_re);
            push_frame(chg_re, oim, st);
         end
         if (rst_at >= 0 && !done_rst && (acc_total - base) >= rst_at) begin
            done_rst = 1'b1;
            ready = 1'b0;
            q.delete();
            do_reset();
            push_frame(ore, oim, st);
         end
      end
      check(q.size() == 0, "drain_timeout",
            $sformatf("got %0d points still pending, want 0", q.size()));
      ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin : mon
      bit          rst_smp;
      bit          hold_v;
      int          bub;
      logic [34:0] held;
      exp_t        e;
      bit          ok;
      hold_v = 1'b0;
      bub = 0;
      held = '0;
      forever begin
         @(posedge clk);
         rst_smp = !resetn;
         @(negedge clk);
         if (rst_smp) begin
            check(valid === 1'b0 && x === 16'sd0 && y === 16'sd0 && {first, lastx, lasty} === 3'b000,
                  "reset_zero", $sformatf("got v=%b x=%0d y=%0d f/lx/ly=%b%b%b, want all 0",
                  valid, x, y, first, lastx, lasty));
            hold_v = 1'b0;
            bub = 0;
         end else begin
            if (hold_v) begin
               check({x, y, first, lastx, lasty} === held && valid === 1'b1, "hold_stable",
                     $sformatf("got v=%b x=%0d y=%0d flags=%b%b%b, want held x=%0d y=%0d flags=%b",
                     valid, x, y, first, lastx, lasty, $signed(held[34:19]), $signed(held[18:3]), held[2:0]));
            end
            if (bub == 1) begin
               check(valid === 1'b0, "frame_bubble", $sformatf("got valid=%b, want 0", valid));
               bub = 2;
            end else if (bub == 2) begin
               check(valid === 1'b1, "post_bubble", $sformatf("got valid=%b, want 1", valid));
               bub = 0;
            end
            hold_v = (valid === 1'b1) && (ready === 1'b0);
            held = {x, y, first, lastx, lasty};
            if (valid === 1'b1 && ready === 1'b1) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_point: got x=%0d y=%0d, want no point", x, y);
               end else begin
                  e = q.pop_front();
                  ok = (int'(x) == e.x) && (int'(y) == e.y) &&
                       (first === e.f) && (lastx === e.lx) && (lasty === e.ly);
                  check(ok, "point", $sformatf("#%0d got x=%0d y=%0d f/lx/ly=%b%b%b, want x=%0d y=%0d f/lx/ly=%b%b%b",
                        acc_total, x, y, first, lastx, lasty, e.x, e.y, e.f, e.lx, e.ly));
                  if (e.ly) bub = 1;
               end
               acc_total++;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int ore, oim, st;
      run_phase(100, 60, 10, 2, 0, -1, 0, -1);
      run_phase(100, 60, 10, 2, 1, -1, 0, -1);
      run_phase(32000, -32700, 1000, 1, 0, -1, 0, -1);
      run_phase(100, 60, 10, 1, 0, 5, 500, -1);
      run_phase(100, 60, 10, 1, 0, -1, 0, 6);
      run_phase(-1234, 777, 0, 1, 0, -1, 0, -1);
      for (int i = 0; i < 4; i++) begin
         ore = int'($urandom_range(0, 65535)) - 32768;
         oim = int'($urandom_range(0, 65535)) - 32768;
         st  = int'($urandom_range(0, 65535));
         run_phase(ore, oim, st, 2, 2, -1, 0, -1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
